rl_shi_reg_unld: RTL and testbench

256-bit left-shift result register with a word-serial unload port, the write-side counterpart of the 256-bit right-shift operand loader in the modular-division datapath. The core shifts the register left one bit per step during reduction, taking a new LSB from the datapath and exposing the outgoing MSB. A small controller then drains the 256-bit result as sixteen 16-bit words, most-significant word first, over a valid/ready handshake.

---
 rtl/rl_shi_reg_unld_if.sv | 25 ++
 rtl/rl_shi_reg_unld.sv | 65 ++++++
 tb/tb_rl_shi_reg_unld.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/rl_shi_reg_unld_if.sv
// Handshake and data bundle for the 256-bit left-shift result register.
// The master drives commands and consumer ready. The slave is the register with its unload port.
interface rl_shi_reg_unld_if;
    logic        wr_vld;
    logic [15:0] wr_data;
    logic        shl1;
    logic        bit_in;
    logic        rd_start;
    logic        dout_rdy;
    logic        msb_out;
    logic [15:0] dout;
    logic        dout_vld;
    logic        done;
    logic        busy;

    modport master (
        output wr_vld, wr_data, shl1, bit_in, rd_start, dout_rdy,
        input  msb_out, dout, dout_vld, done, busy
    );

    modport slave (
        input  wr_vld, wr_data, shl1, bit_in, rd_start, dout_rdy,
        output msb_out, dout, dout_vld, done, busy
    );
endinterface

// File: rtl/rl_shi_reg_unld.sv
// 256-bit left-shift result register. In IDLE it takes bit or word shifts.
// It then drains its contents as sixteen 16-bit words, MSW first, over valid/ready.
module rl_shi_reg_unld (
    input  logic             clk,
    input  logic             clr,
    rl_shi_reg_unld_if.slave bus
);
    typedef enum logic [1:0] {IDLE, UNLOAD, DONE} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [255:0] r;
    logic [3:0]   cnt;
    logic         accept;

    assign accept = (state == UNLOAD) && bus.dout_rdy;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.rd_start) state_nxt = UNLOAD;
            UNLOAD:  if (accept && cnt == 4'd15) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.dout_vld = (state == UNLOAD);
        bus.done     = (state == DONE);
        bus.busy     = (state == UNLOAD) || (state == DONE);
    end

    // Commands on the same IDLE edge: rd_start wins, then shl1, then wr_vld.
    // Commands that lose are dropped.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r   <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rd_start)    cnt <= '0;
                    else if (bus.shl1)   r   <= {r[254:0], bus.bit_in};
                    else if (bus.wr_vld) r   <= {r[239:0], bus.wr_data};
                end
                UNLOAD: begin
                    if (accept) begin
                        r   <= {r[239:0], 16'h0000};
                        cnt <= cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.msb_out = r[255];
    assign bus.dout    = r[255:240];
endmodule

// File: tb/tb_rl_shi_reg_unld.sv
// Directed test of rl_shi_reg_unld. It covers reset, word and bit loading, unload with and without backpressure,
// command priority and ignore rules, and clr in the middle of an unload.
module tb_rl_shi_reg_unld;
    logic clk;
    logic clr;
    int unsigned compared;
    int unsigned mismatched;
    logic [15:0] exp_w [16];

    rl_shi_reg_unld_if bus ();

    rl_shi_reg_unld dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cmds();
        bus.wr_vld   = 1'b0;
        bus.wr_data  = 16'h0000;
        bus.shl1     = 1'b0;
        bus.bit_in   = 1'b0;
        bus.rd_start = 1'b0;
    endtask

    task automatic write_word(input logic [15:0] w);
        bus.wr_vld  = 1'b1;
        bus.wr_data = w;
        step();
        bus.wr_vld  = 1'b0;
    endtask

    // When bp is set, dout_rdy follows the repeating pattern 1,0,0.
    // When junk is set, wr_vld/FFFF and shl1 are driven all through UNLOAD and DONE.
    task automatic do_unload(input bit bp, input bit junk);
        int unsigned k;
        int unsigned cyc;
        bus.rd_start = 1'b1;
        bus.dout_rdy = 1'b0;
        step();
        bus.rd_start = 1'b0;
        if (junk) begin
            bus.wr_vld  = 1'b1;
            bus.wr_data = 16'hFFFF;
            bus.shl1    = 1'b1;
            bus.bit_in  = 1'b1;
        end
        k   = 0;
        cyc = 0;
        while (k < 16 && cyc < 100) begin
            chk("unld_vld", bus.dout_vld, 1'b1);
            chk("unld_busy", bus.busy, 1'b1);
            chk("unld_done_low", bus.done, 1'b0);
            chk("unld_word", bus.dout, exp_w[k]);
            bus.dout_rdy = bp ? (cyc % 3 == 0) : 1'b1;
            step();
            if (bus.dout_rdy) k++;
            cyc++;
        end
        chk("unld_accepts", k, 16);
        chk("unld_cycles", cyc, bp ? 46 : 16);
        bus.dout_rdy = 1'b0;
        chk("done_pulse", bus.done, 1'b1);
        chk("done_vld_low", bus.dout_vld, 1'b0);
        chk("done_busy", bus.busy, 1'b1);
        chk("done_r_zero", bus.dout, 16'h0000);
        // A command held during the DONE cycle must be ignored.
        bus.wr_vld  = 1'b1;
        bus.wr_data = 16'hBEEF;
        step();
        idle_cmds();
        chk("idle_done_low", bus.done, 1'b0);
        chk("idle_busy_low", bus.busy, 1'b0);
        chk("idle_dout_zero", bus.dout, 16'h0000);
        chk("idle_msb_zero", bus.msb_out, 1'b0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        idle_cmds();
        bus.dout_rdy = 1'b0;
        clr = 1'b1;
        #1;
        chk("rst_dout", bus.dout, 16'h0000);
        chk("rst_msb", bus.msb_out, 1'b0);
        chk("rst_vld", bus.dout_vld, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        step();
        clr = 1'b0;
        step();

        // Asynchronous clear while R is nonzero
        write_word(16'hFFFF);
        chk("pre_clr_dout", bus.dout, 16'h0000);
        for (int i = 0; i < 15; i++) write_word(16'h8001);
        chk("pre_clr_top", bus.dout, 16'hFFFF);
        chk("pre_clr_msb", bus.msb_out, 1'b1);
        #2;
        clr = 1'b1;
        #1;
        chk("async_clr_dout", bus.dout, 16'h0000);
        chk("async_clr_msb", bus.msb_out, 1'b0);
        #1;
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_clr_dout", bus.dout, 16'h0000);
            chk("post_clr_busy", bus.busy, 1'b0);
            chk("post_clr_vld", bus.dout_vld, 1'b0);
        end

        // Word load 0001..0010, then unload with ready held high
        for (int i = 0; i < 16; i++) begin
            write_word(16'(i + 1));
            exp_w[i] = 16'(i + 1);
        end
        do_unload(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) exp_w[i] = 16'h0000;
        do_unload(1'b0, 1'b0);

        // 256 single-bit shifts, alternating starting with 1
        for (int i = 0; i < 256; i++) begin
            bus.shl1   = 1'b1;
            bus.bit_in = (i % 2 == 0);
            step();
        end
        idle_cmds();
        chk("shl1_msb", bus.msb_out, 1'b1);
        chk("shl1_top", bus.dout, 16'hAAAA);
        for (int i = 0; i < 16; i++) exp_w[i] = 16'hAAAA;
        do_unload(1'b1, 1'b0);

        // Priority: rd_start + shl1 + wr_vld together; then junk writes throughout UNLOAD
        for (int i = 0; i < 16; i++) begin
            write_word(16'h1000 + 16'(i));
            exp_w[i] = 16'h1000 + 16'(i);
        end
        bus.shl1    = 1'b1;
        bus.bit_in  = 1'b1;
        bus.wr_vld  = 1'b1;
        bus.wr_data = 16'h5555;
        do_unload(1'b0, 1'b1);

        // clr after 5 accepts discards the rest of the unload
        for (int i = 0; i < 16; i++) write_word(16'(i + 1));
        bus.rd_start = 1'b1;
        bus.dout_rdy = 1'b1;
        step();
        bus.rd_start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("mid_word6", bus.dout, 16'h0006);
        bus.dout_rdy = 1'b0;
        #2;
        clr = 1'b1;
        #1;
        chk("mid_clr_vld", bus.dout_vld, 1'b0);
        chk("mid_clr_busy", bus.busy, 1'b0);
        chk("mid_clr_dout", bus.dout, 16'h0000);
        #1;
        clr = 1'b0;
        step();
        chk("mid_clr_no_done", bus.done, 1'b0);
        chk("mid_clr_idle_vld", bus.dout_vld, 1'b0);
        write_word(16'h1234);
        for (int i = 0; i < 15; i++) exp_w[i] = 16'h0000;
        exp_w[15] = 16'h1234;
        do_unload(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
